tile_transpose_stream: RTL and testbench
========================================

TILE_TRANSPOSE_STREAM -- requirements
Module: tile_transpose_stream

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning element width in bits (legal 1..32).
REQ-002 The block SHALL have parameter N, default 8, meaning tile dimension, N x N elements, power of two 2..16.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL change on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port cfg_bypass, input, 1 bit: 1 = pass tile unchanged, 0 = transpose.
REQ-006 The block SHALL have ports s_valid (input, 1), s_ready (output, 1) and s_data (input, N*DATA_W), carrying one tile row per beat; element k is at bits [k*DATA_W +: DATA_W].
REQ-007 The block SHALL have ports m_valid (output, 1), m_ready (input, 1), m_data (output, N*DATA_W) and m_last (output, 1), carrying one output row per beat; m_last marks row N-1.
REQ-008 The block SHALL have port tile_count, output, 16 bits: number of tiles fully emitted, wrapping at 2^16.
REQ-009 The block SHALL have port busy, output, 1 bit: high when any bank is full or a tile is partially written.

Function
REQ-010 The block SHALL contain two N x N banks (ping-pong), each with a full flag and a stored mode bit.
REQ-011 The input side SHALL accept a beat when s_valid && s_ready, writing s_data into row wr_row of bank wr_bank.
REQ-012 s_ready SHALL equal !full[wr_bank], with no combinational path from s_valid or m_ready.
REQ-013 cfg_bypass SHALL be captured into the bank mode bit on the handshake of row 0 only; changes mid-tile SHALL have no effect on that tile.
REQ-014 On the handshake of row N-1, the block SHALL set full[wr_bank], clear wr_row to 0 and toggle wr_bank.
REQ-015 m_valid SHALL equal full[rd_bank]; the first output beat of a tile SHALL be valid the cycle after its row N-1 input handshake (latency 1).
REQ-016 For output row r in transpose mode, element k of m_data SHALL be bank[rd_bank] element (row k, column r); in bypass mode it SHALL be (row r, column k).
REQ-017 m_data and m_last SHALL hold stable while m_valid && !m_ready.
REQ-018 On output handshake, rd_row SHALL increment; on the handshake with rd_row==N-1, the block SHALL clear full[rd_bank], reset rd_row to 0, toggle rd_bank and increment tile_count.
REQ-019 Set of full on one bank and clear of full on the other bank in the same cycle SHALL both take effect, sustaining one row per cycle in each direction.
REQ-020 When both banks are full, s_ready SHALL be 0 until the reader frees a bank; the freed bank SHALL be writable the cycle after the freeing handshake.
REQ-021 tile_count SHALL wrap from 16'hFFFF to 0 without side effects.
REQ-022 Row counters SHALL be $clog2(N) bits and wrap only as defined in REQ-014/018.

Reset
REQ-023 On rst_n low, the block SHALL asynchronously clear: full flags, wr_bank, rd_bank, wr_row, rd_row, tile_count, busy, m_valid, m_last; s_ready SHALL be 1 after release.
REQ-024 Bank contents SHALL NOT be reset, and m_data SHALL be don't-care while m_valid is 0.
REQ-025 Reset asserted mid-tile SHALL discard all partial and buffered tiles; the first post-reset row SHALL be row 0 into bank 0.

Verification
REQ-026 N=8, one tile with element(i,j)=i*8+j, cfg_bypass=0, m_ready=1 -> output row r element k = k*8+r, m_last on the 8th beat, tile_count=1.
REQ-027 Same tile with cfg_bypass=1 -> output identical to input rows; cfg_bypass toggled at row 3 -> no effect.
REQ-028 Three back-to-back tiles, m_ready held 0 -> s_ready drops after the 16th row, busy=1; release m_ready -> 24 rows out in order, tile_count=3.
REQ-029 Continuous streaming with s_valid=m_ready=1 for 10 tiles -> no bubbles after the first tile, one row per cycle, tile_count=10.
REQ-030 rst_n pulsed after row 4 of a tile -> m_valid=0, tile_count=0, s_ready=1; the next full tile is emitted correctly.
REQ-031 Random valid/ready throttling over 200 tiles against a reference model -> zero mismatches, m_data stable under backpressure.

Source files
------------

// File: rtl/tile_transpose_stream_if.sv
// rtl/tile_transpose_stream_if.sv - row-stream handshake bundle for tile_transpose_stream
interface tile_transpose_stream_if #(
  parameter int DATA_W = 16,
  parameter int N      = 8
);
  logic                  s_valid;
  logic                  s_ready;
  logic [N*DATA_W-1:0]   s_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [N*DATA_W-1:0]   m_data;
  logic                  m_last;

  // master: the environment that produces input rows and consumes output rows
  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_last
  );
endinterface

// File: rtl/tile_transpose_stream.sv
// rtl/tile_transpose_stream.sv - ping-pong N x N tile buffer emitting rows transposed or unchanged
module tile_transpose_stream #(
  parameter int DATA_W = 16,
  parameter int N      = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_bypass,
  tile_transpose_stream_if.slave   bus,
  output logic [15:0]              tile_count,
  output logic                     busy
);
  localparam int RW = $clog2(N);
  localparam logic [RW-1:0] LAST_ROW = RW'(N - 1);

  logic [DATA_W-1:0] mem_q [2][N][N];
  logic [DATA_W-1:0] row_in [N];

  logic [1:0]    full_q, full_d;
  logic [1:0]    mode_q, mode_d;
  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic [RW-1:0] wr_row_q, wr_row_d;
  logic [RW-1:0] rd_row_q, rd_row_d;
  logic [15:0]   tile_count_q, tile_count_d;
  logic          wr_fire, rd_fire;

  // ready/valid depend only on registered full flags, never on the partner handshake
  assign bus.s_ready = !full_q[wr_bank_q];
  assign bus.m_valid = full_q[rd_bank_q];
  assign bus.m_last  = full_q[rd_bank_q] && (rd_row_q == LAST_ROW);

  assign wr_fire = bus.s_valid && !full_q[wr_bank_q];
  assign rd_fire = full_q[rd_bank_q] && bus.m_ready;

  assign tile_count = tile_count_q;
  assign busy       = (|full_q) || (wr_row_q != '0);

  always_comb begin
    full_d       = full_q;
    mode_d       = mode_q;
    wr_bank_d    = wr_bank_q;
    rd_bank_d    = rd_bank_q;
    wr_row_d     = wr_row_q;
    rd_row_d     = rd_row_q;
    tile_count_d = tile_count_q;

    if (wr_fire) begin
      if (wr_row_q == '0) begin
        mode_d[wr_bank_q] = cfg_bypass;
      end
      if (wr_row_q == LAST_ROW) begin
        full_d[wr_bank_q] = 1'b1;
        wr_row_d          = '0;
        wr_bank_d         = !wr_bank_q;
      end else begin
        wr_row_d = wr_row_q + 1'b1;
      end
    end

    // writer and reader always address different banks, so both updates can land together
    if (rd_fire) begin
      if (rd_row_q == LAST_ROW) begin
        full_d[rd_bank_q] = 1'b0;
        rd_row_d          = '0;
        rd_bank_d         = !rd_bank_q;
        tile_count_d      = tile_count_q + 16'd1;
      end else begin
        rd_row_d = rd_row_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q       <= '0;
      mode_q       <= '0;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      wr_row_q     <= '0;
      rd_row_q     <= '0;
      tile_count_q <= '0;
    end else begin
      full_q       <= full_d;
      mode_q       <= mode_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      wr_row_q     <= wr_row_d;
      rd_row_q     <= rd_row_d;
      tile_count_q <= tile_count_d;
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_col
    assign row_in[k] = bus.s_data[k*DATA_W +: DATA_W];
    assign bus.m_data[k*DATA_W +: DATA_W] = mode_q[rd_bank_q]
                                          ? mem_q[rd_bank_q][rd_row_q][k]
                                          : mem_q[rd_bank_q][k][rd_row_q];
  end

  // tile storage is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[wr_bank_q][wr_row_q] <= row_in;
    end
  end
endmodule

// File: tb/tb_tile_transpose_stream.sv
// tb/tb_tile_transpose_stream.sv - directed and throttled checks of tile_transpose_stream
module tb_tile_transpose_stream;
  localparam int DW = 16;
  localparam int N  = 8;
  localparam int W  = DW * N;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_bypass = 1'b0;
  logic [15:0] tile_count;
  logic        busy;

  tile_transpose_stream_if #(.DATA_W(DW), .N(N)) bus ();

  tile_transpose_stream #(.DATA_W(DW), .N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_bypass (cfg_bypass),
    .bus        (bus),
    .tile_count (tile_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [W-1:0] tile_buf [N];
  logic [W-1:0] exp_q [$];
  int           drv_row = 0;
  logic         drv_mode = 1'b0;
  int           stall_cnt = 0;
  bit           rand_rdy = 1'b0;

  function automatic logic [W-1:0] expect_row(input int r, input logic byp);
    logic [W-1:0] v;
    for (int k = 0; k < N; k++) begin
      v[k*DW +: DW] = byp ? tile_buf[r][k*DW +: DW] : tile_buf[k][r*DW +: DW];
    end
    return v;
  endfunction

  function automatic logic [W-1:0] ident_row(input int i);
    logic [W-1:0] v;
    for (int j = 0; j < N; j++) v[j*DW +: DW] = DW'(i*8 + j);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_rdy) bus.m_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send_row(input logic [W-1:0] d, input logic byp);
    int n;
    n = 0;
    bus.s_data  = d;
    cfg_bypass  = byp;
    bus.s_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.s_ready || n >= 3000) break;
      n++;
      step();
    end
    if (!bus.s_ready) check("s_ready_timeout", W'(bus.s_ready), W'(1));
    stall_cnt += n;
    if (drv_row == 0) drv_mode = byp;
    tile_buf[drv_row] = d;
    if (drv_row == N-1) begin
      for (int r = 0; r < N; r++) exp_q.push_back(expect_row(r, drv_mode));
      drv_row = 0;
    end else begin
      drv_row++;
    end
    step();
  endtask

  task automatic send_ident(input logic byp, input int flip_at);
    for (int i = 0; i < N; i++) send_row(ident_row(i), (i >= flip_at) ? !byp : byp);
  endtask

  task automatic send_rand(input logic byp, input bit gaps);
    logic [W-1:0] v;
    for (int i = 0; i < N; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        bus.s_valid = 1'b0;
        repeat ($urandom_range(1, 3)) step();
      end
      for (int j = 0; j < N; j++) v[j*DW +: DW] = DW'($urandom);
      send_row(v, byp);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      step();
      n++;
    end
    check("drain_empty", W'(exp_q.size()), W'(0));
    step();
  endtask

  int          out_row = 0;
  logic        stall_prev = 1'b0;
  logic [W-1:0] data_prev;
  logic        last_prev;
  logic [W-1:0] exp_row;
  bit          have_exp;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      out_row    = 0;
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", W'(bus.m_valid), W'(1));
        check("hold_data", bus.m_data, data_prev);
        check("hold_last", W'(bus.m_last), W'(last_prev));
      end
      if (bus.m_valid && bus.m_ready) begin
        have_exp = (exp_q.size() != 0);
        check("beat_expected", W'(have_exp), W'(1));
        if (have_exp) begin
          exp_row = exp_q.pop_front();
          check("m_data", bus.m_data, exp_row);
        end
        check("m_last", W'(bus.m_last), W'(out_row == N-1));
        out_row = (out_row + 1) % N;
      end
      stall_prev = bus.m_valid && !bus.m_ready;
      data_prev  = bus.m_data;
      last_prev  = bus.m_last;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] hrow;
    logic         byp;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;
    rst_n       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", W'(bus.m_valid), W'(0));
    check("rst_m_last", W'(bus.m_last), W'(0));
    check("rst_busy", W'(busy), W'(0));
    check("rst_tile_count", W'(tile_count), W'(0));
    rst_n = 1'b1;
    step();
    check("rst_s_ready", W'(bus.s_ready), W'(1));

    // single transposed tile, first beat one cycle after row N-1
    bus.m_ready = 1'b1;
    send_ident(1'b0, N);
    bus.s_valid = 1'b0;
    for (int k = 0; k < N; k++) hrow[k*DW +: DW] = DW'(k*8);
    check("lat_m_valid", W'(bus.m_valid), W'(1));
    check("row0_transpose", bus.m_data, hrow);
    check("row0_not_last", W'(bus.m_last), W'(0));
    drain();
    check("tile_count_1", W'(tile_count), W'(16'd1));

    // bypass tile with cfg_bypass flipped from row 3 on
    send_ident(1'b1, 3);
    bus.s_valid = 1'b0;
    check("row0_bypass", bus.m_data, ident_row(0));
    drain();
    check("tile_count_2", W'(tile_count), W'(16'd2));

    // both banks fill while the reader is stalled
    bus.m_ready = 1'b0;
    send_ident(1'b0, N);
    send_ident(1'b1, N);
    bus.s_valid = 1'b0;
    check("full_s_ready", W'(bus.s_ready), W'(0));
    check("full_busy", W'(busy), W'(1));
    check("full_m_valid", W'(bus.m_valid), W'(1));
    fork
      begin
        send_ident(1'b0, N);
        bus.s_valid = 1'b0;
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        bus.m_ready = 1'b1;
      end
    join
    drain();
    check("tile_count_5", W'(tile_count), W'(16'd5));

    // ten tiles streamed back to back
    stall_cnt = 0;
    fork
      begin
        for (int t = 0; t < 10; t++) begin
          byp = 1'($urandom_range(0, 1));
          send_rand(byp, 1'b0);
        end
        bus.s_valid = 1'b0;
      end
      begin
        int h, c, n;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!bus.m_valid && n < 200);
        h = 0;
        c = 0;
        while (h < 80 && c < 400) begin
          if (bus.m_valid && bus.m_ready) h++;
          c++;
          if (h < 80) @(negedge clk);
        end
        check("stream_cycles", W'(c), W'(80));
      end
    join
    check("stream_in_stalls", W'(stall_cnt), W'(0));
    drain();
    check("tile_count_15", W'(tile_count), W'(16'd15));

    // reset in the middle of a tile
    for (int i = 0; i < 5; i++) send_row(ident_row(i), 1'b0);
    rst_n       = 1'b0;
    bus.s_valid = 1'b0;
    drv_row     = 0;
    @(negedge clk);
    check("mid_rst_m_valid", W'(bus.m_valid), W'(0));
    check("mid_rst_tile_count", W'(tile_count), W'(0));
    check("mid_rst_busy", W'(busy), W'(0));
    step();
    rst_n = 1'b1;
    check("mid_rst_s_ready", W'(bus.s_ready), W'(1));
    send_ident(1'b0, N);
    bus.s_valid = 1'b0;
    check("post_rst_row0", bus.m_data, hrow);
    drain();
    check("post_rst_tile_count", W'(tile_count), W'(16'd1));

    // throttled traffic on both sides
    rand_rdy = 1'b1;
    for (int t = 0; t < 200; t++) begin
      byp = 1'($urandom_range(0, 1));
      send_rand(byp, 1'b1);
    end
    bus.s_valid = 1'b0;
    rand_rdy    = 1'b0;
    bus.m_ready = 1'b1;
    drain();
    check("tile_count_201", W'(tile_count), W'(16'd201));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
